// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM/WB operand forwarding and load-use bubbling.
// Defining ID_EX_STALL_CNT_EN adds the stall_cnt / bubble_cnt performance counters.

module id_ex_fwd #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            rs_use,
    input  logic [AW-1:0]   rs_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_fwd_en,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_reg_we,
    input  logic [AW-1:0]   mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_we,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] rs_val
);
    // Youngest producer wins; x0 is hardwired and never forwarded.
    always_comb begin
        rs_val = rf_data;
        if (!rs_use || rs_addr == '0)
            rs_val = '0;
        else if (ex_fwd_en && ex_rd == rs_addr)
            rs_val = ex_result;
        else if (mem_reg_we && mem_rd_addr == rs_addr)
            rs_val = mem_result;
        else if (wb_reg_we && wb_rd_addr == rs_addr)
            rs_val = wb_result;
    end
endmodule

module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [AW-1:0]   id_rs1_addr,
    input  logic [AW-1:0]   id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic            id_reg_we,
    input  logic            id_mem_read,
    input  logic [XLEN-1:0] id_imm,
    input  logic [OPW-1:0]  id_alu_op,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_reg_we,
    input  logic [AW-1:0]   mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_we,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [AW-1:0]   ex_rd_addr,
    output logic            ex_reg_we,
    output logic            ex_mem_read,
    output logic [OPW-1:0]  ex_alu_op
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     bubble_cnt
`endif
);
    localparam int NOPS = 2;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [AW-1:0]   rd;
        logic            we;
        logic            mr;
        logic [OPW-1:0]  op;
    } ex_pkt_t;

    ex_pkt_t ex_q, ex_d;

    logic [NOPS-1:0]           rs_use;
    logic [NOPS-1:0][AW-1:0]   rs_addr;
    logic [NOPS-1:0][XLEN-1:0] rf_data;
    logic [NOPS-1:0][XLEN-1:0] rs_val;
    logic [NOPS-1:0]           lu_hit;
    logic                      ex_fwd_en;
    logic                      lu;
    logic                      bubble;

    assign rs_use  = {id_use_rs2, id_use_rs1};
    assign rs_addr = {id_rs2_addr, id_rs1_addr};
    assign rf_data = {id_rs2_data, id_rs1_data};

    // A load in EX has no data yet, so it is excluded here and handled as a hazard.
    assign ex_fwd_en = ex_q.valid && ex_q.we && !ex_q.mr;

    for (genvar g = 0; g < NOPS; g++) begin : g_opnd
        id_ex_fwd #(.XLEN(XLEN), .AW(AW)) u_fwd (
            .rs_use     (rs_use[g]),
            .rs_addr    (rs_addr[g]),
            .rf_data    (rf_data[g]),
            .ex_fwd_en  (ex_fwd_en),
            .ex_rd      (ex_q.rd),
            .ex_result  (ex_result),
            .mem_reg_we (mem_reg_we),
            .mem_rd_addr(mem_rd_addr),
            .mem_result (mem_result),
            .wb_reg_we  (wb_reg_we),
            .wb_rd_addr (wb_rd_addr),
            .wb_result  (wb_result),
            .rs_val     (rs_val[g])
        );
        assign lu_hit[g] = rs_use[g] && (rs_addr[g] == ex_q.rd);
    end

    assign lu = ex_q.valid && ex_q.mr && (ex_q.rd != '0) && id_valid && (|lu_hit);

    // Gated by rst so the hold request reads 0 throughout reset.
    assign id_stall = rst && (ex_stall || (lu && !flush));

    always_comb begin
        ex_d   = ex_q;
        bubble = 1'b0;
        if (flush) begin
            bubble = 1'b1;
        end else if (ex_stall) begin
            ex_d = ex_q;
        end else if (lu || !id_valid) begin
            bubble = 1'b1;
        end else begin
            ex_d.valid = 1'b1;
            ex_d.pc    = id_pc;
            ex_d.imm   = id_imm;
            ex_d.rs1   = rs_val[0];
            ex_d.rs2   = rs_val[1];
            ex_d.rd    = id_rd_addr;
            ex_d.we    = id_reg_we;
            ex_d.mr    = id_mem_read;
            ex_d.op    = id_alu_op;
        end
        if (bubble)
            ex_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1_val  = ex_q.rs1;
    assign ex_rs2_val  = ex_q.rs2;
    assign ex_rd_addr  = ex_q.rd;
    assign ex_reg_we   = ex_q.we;
    assign ex_mem_read = ex_q.mr;
    assign ex_alu_op   = ex_q.op;

`ifdef ID_EX_STALL_CNT_EN
    // bubble already excludes held cycles, so only the stall count needs the ex_stall gate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (lu && !flush && !ex_stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (bubble)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed + random checks of id_ex_stage against a cycle-level reference model.
// Counter checks are compiled in when ID_EX_STALL_CNT_EN is defined.

module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int OPW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_use_rs1, id_use_rs2, id_reg_we, id_mem_read;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [AW-1:0]   id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [OPW-1:0]  id_alu_op;
    logic [XLEN-1:0] ex_result, mem_result, wb_result;
    logic            mem_reg_we, wb_reg_we, ex_stall, flush;
    logic [AW-1:0]   mem_rd_addr, wb_rd_addr;
    logic            id_stall, ex_valid, ex_reg_we, ex_mem_read;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [AW-1:0]   ex_rd_addr;
    logic [OPW-1:0]  ex_alu_op;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]     stall_cnt, bubble_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .AW(AW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_addr(id_rd_addr), .id_reg_we(id_reg_we), .id_mem_read(id_mem_read),
        .id_imm(id_imm), .id_alu_op(id_alu_op),
        .ex_result(ex_result),
        .mem_reg_we(mem_reg_we), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_we(wb_reg_we), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .ex_stall(ex_stall), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd_addr(ex_rd_addr),
        .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_alu_op(ex_alu_op)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model of what EX should hold.
    logic            m_valid, m_we, m_mr;
    logic [XLEN-1:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [AW-1:0]   m_rd;
    logic [OPW-1:0]  m_op;
    logic [31:0]     m_stall_cnt, m_bub_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_we = 0; m_mr = 0; m_pc = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_stall_cnt = 0;
        m_bub_cnt   = 0;
    endtask

    function automatic logic [XLEN-1:0] resolve(input logic u, input logic [AW-1:0] a,
                                                input logic [XLEN-1:0] d);
        if (!u || a == 0)                         return 0;
        if (m_valid && m_we && !m_mr && m_rd == a) return ex_result;
        if (mem_reg_we && mem_rd_addr == a)       return mem_result;
        if (wb_reg_we && wb_rd_addr == a)         return wb_result;
        return d;
    endfunction

    task automatic check_state(input string p);
        chk({p, ".valid"}, ex_valid, m_valid);
        chk({p, ".pc"}, ex_pc, m_pc);
        chk({p, ".imm"}, ex_imm, m_imm);
        chk({p, ".rs1"}, ex_rs1_val, m_rs1);
        chk({p, ".rs2"}, ex_rs2_val, m_rs2);
        chk({p, ".rd"}, ex_rd_addr, m_rd);
        chk({p, ".we"}, ex_reg_we, m_we);
        chk({p, ".mr"}, ex_mem_read, m_mr);
        chk({p, ".op"}, ex_alu_op, m_op);
`ifdef ID_EX_STALL_CNT_EN
        chk({p, ".stall_cnt"}, stall_cnt, m_stall_cnt);
        chk({p, ".bubble_cnt"}, bubble_cnt, m_bub_cnt);
`endif
    endtask

    // One clock: check id_stall now, advance the model at the edge, check EX after it.
    task automatic cycle(input string p);
        logic lu, bub, hold;
        logic [XLEN-1:0] r1, r2;
        #1;
        lu = m_valid && m_mr && m_rd != 0 && id_valid &&
             ((id_use_rs1 && id_rs1_addr == m_rd) || (id_use_rs2 && id_rs2_addr == m_rd));
        chk({p, ".id_stall"}, id_stall, ex_stall || (lu && !flush));
        r1   = resolve(id_use_rs1, id_rs1_addr, id_rs1_data);
        r2   = resolve(id_use_rs2, id_rs2_addr, id_rs2_data);
        hold = !flush && ex_stall;
        bub  = flush || (!ex_stall && (lu || !id_valid));
        @(posedge clk);
        if (lu && !flush && !ex_stall) m_stall_cnt++;
        if (bub) begin
            model_clear();
            m_bub_cnt++;
        end else if (!hold) begin
            m_valid = 1; m_pc = id_pc; m_imm = id_imm; m_rs1 = r1; m_rs2 = r2;
            m_rd = id_rd_addr; m_we = id_reg_we; m_mr = id_mem_read; m_op = id_alu_op;
        end
        #1;
        check_state(p);
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_rd_addr = 0; id_reg_we = 0; id_mem_read = 0; id_imm = 0; id_alu_op = 0;
        ex_result = 0; mem_reg_we = 0; mem_rd_addr = 0; mem_result = 0;
        wb_reg_we = 0; wb_rd_addr = 0; wb_result = 0; ex_stall = 0; flush = 0;
    endtask

    // Small address range so forwarding and hazards happen often.
    task automatic rand_inputs();
        id_valid    = ($urandom_range(0, 3) != 0);
        id_pc       = $urandom;
        id_use_rs1  = $urandom_range(0, 1);
        id_use_rs2  = $urandom_range(0, 1);
        id_rs1_addr = AW'($urandom_range(0, 7));
        id_rs2_addr = AW'($urandom_range(0, 7));
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_rd_addr  = AW'($urandom_range(0, 7));
        id_reg_we   = $urandom_range(0, 1);
        id_mem_read = ($urandom_range(0, 2) == 0);
        id_imm      = $urandom;
        id_alu_op   = OPW'($urandom);
        ex_result   = $urandom;
        mem_reg_we  = $urandom_range(0, 1);
        mem_rd_addr = AW'($urandom_range(0, 7));
        mem_result  = $urandom;
        wb_reg_we   = $urandom_range(0, 1);
        wb_rd_addr  = AW'($urandom_range(0, 7));
        wb_result   = $urandom;
        ex_stall    = ($urandom_range(0, 7) == 0);
        flush       = ($urandom_range(0, 15) == 0);
    endtask

    task automatic load_x(input logic [AW-1:0] rd);
        idle();
        id_valid = 1; id_reg_we = 1; id_mem_read = 1; id_rd_addr = rd; id_pc = 32'h100;
    endtask

    initial begin
        logic [XLEN-1:0] s_pc, s_imm, s_rs1, s_rs2;

        // Reset with random inputs.
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            #2;
            check_state("reset");
            chk("reset.id_stall", id_stall, 1'b0);
            @(posedge clk);
            #1;
        end
        idle();
        rst = 1;

        id_valid = 1; id_use_rs1 = 1; id_rs1_addr = 3; id_rs1_data = 32'h11;
        cycle("first");
        chk("first.rs1", ex_rs1_val, 32'h11);
        chk("first.valid", ex_valid, 1'b1);

        // Forward priority EX > MEM > WB, and x0.
        idle();
        id_valid = 1; id_reg_we = 1; id_rd_addr = 5;
        cycle("fw_setup");
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1_addr = 5; id_rs1_data = 32'hDEAD;
        ex_result = 32'hA;
        mem_reg_we = 1; mem_rd_addr = 5; mem_result = 32'hB;
        wb_reg_we = 1; wb_rd_addr = 5; wb_result = 32'hC;
        cycle("fw_ex");
        chk("fw_ex.rs1", ex_rs1_val, 32'hA);
        cycle("fw_mem");
        chk("fw_mem.rs1", ex_rs1_val, 32'hB);
        mem_reg_we = 0;
        cycle("fw_wb");
        chk("fw_wb.rs1", ex_rs1_val, 32'hC);
        idle();
        id_valid = 1; id_reg_we = 1; id_rd_addr = 0;
        cycle("fw0_setup");
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1_addr = 0; id_rs1_data = 32'h77;
        ex_result = 32'hA;
        mem_reg_we = 1; mem_rd_addr = 0; mem_result = 32'hB;
        wb_reg_we = 1; wb_rd_addr = 0; wb_result = 32'hC;
        cycle("fw_x0");
        chk("fw_x0.rs1", ex_rs1_val, 32'h0);

        // Load-use: one bubble, then forward from MEM.
        load_x(7);
        cycle("lu_load");
        idle();
        id_valid = 1; id_use_rs2 = 1; id_rs2_addr = 7; id_rs2_data = 32'h99;
        #1;
        chk("lu.id_stall", id_stall, 1'b1);
        cycle("lu_bubble");
        chk("lu_bubble.valid", ex_valid, 1'b0);
        mem_reg_we = 1; mem_rd_addr = 7; mem_result = 32'h55;
        #1;
        chk("lu_after.id_stall", id_stall, 1'b0);
        cycle("lu_fwd");
        chk("lu_fwd.rs2", ex_rs2_val, 32'h55);

        // Same address but neither operand used: no stall.
        load_x(7);
        cycle("nm_load");
        idle();
        id_valid = 1; id_rs1_addr = 7; id_rs2_addr = 7;
        #1;
        chk("nomatch.id_stall", id_stall, 1'b0);
        cycle("nomatch");

        // Flush beats stall and hazard.
        load_x(7);
        cycle("fl_load");
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1_addr = 7; ex_stall = 1; flush = 1;
        #1;
        chk("flush.id_stall", id_stall, 1'b1);
        cycle("flush");
        chk("flush.valid", ex_valid, 1'b0);

        // ex_stall holds EX constant while decode inputs churn.
        idle();
        id_valid = 1; id_pc = 32'h400; id_imm = 32'h1234; id_use_rs1 = 1; id_rs1_addr = 2;
        id_rs1_data = 32'hAB; id_use_rs2 = 1; id_rs2_addr = 4; id_rs2_data = 32'hCD;
        id_rd_addr = 9; id_reg_we = 1; id_alu_op = 4'h6;
        cycle("hold_cap");
        s_pc = m_pc; s_imm = m_imm; s_rs1 = m_rs1; s_rs2 = m_rs2;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            ex_stall = 1; flush = 0;
            cycle("hold");
            chk("hold.pc", ex_pc, s_pc);
            chk("hold.imm", ex_imm, s_imm);
            chk("hold.rs1", ex_rs1_val, s_rs1);
            chk("hold.rs2", ex_rs2_val, s_rs2);
            chk("hold.valid", ex_valid, 1'b1);
        end

        // Asynchronous reset in the middle of a stall.
        #2;
        rst = 0;
        #1;
        model_reset();
        check_state("midrst");
        chk("midrst.id_stall", id_stall, 1'b0);
        @(posedge clk);
        #1;
        rst = 1;
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1_addr = 7; id_rs1_data = 32'h31;
        cycle("post_rst");
        chk("post_rst.rs1", ex_rs1_val, 32'h31);

`ifdef ID_EX_STALL_CNT_EN
        // Two load-use stalls and one flush from a fresh reset.
        rst = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        load_x(7);
        cycle("cnt_a");
        idle();
        id_valid = 1; id_use_rs2 = 1; id_rs2_addr = 7;
        id_reg_we = 1; id_mem_read = 1; id_rd_addr = 9;
        cycle("cnt_b");
        cycle("cnt_c");
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1_addr = 9;
        cycle("cnt_d");
        flush = 1;
        cycle("cnt_e");
        chk("cnt.stall_cnt", stall_cnt, 32'd2);
        chk("cnt.bubble_cnt", bubble_cnt, 32'd3);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
